// File: rtl/alu_issue_unit_if.sv
// alu_if: connection to a shared combinational ALU.
//   op        [3:0]  operation code (opaque to the issue unit)
//   operand1  [31:0] first operand
//   operand2  [31:0] second operand
//   result    [31:0] ALU result
//   negative, zero, overflow  ALU status flags
// Modport tb  : initiator side (drives op/operands, samples result/flags).
// Modport dut : ALU side (samples op/operands, drives result/flags).
interface alu_if;
  logic [3:0]  op;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [31:0] result;
  logic        negative;
  logic        zero;
  logic        overflow;

  modport tb  (output op, output operand1, output operand2,
               input  result, input negative, input zero, input overflow);
  modport dut (input  op, input operand1, input operand2,
               output result, output negative, output zero, output overflow);
endinterface

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: initiator for a shared combinational ALU.
// Requests arrive on a valid/ready handshake, are registered onto the ALU
// inputs, the ALU result and flags are captured one cycle later into a
// response FIFO, and responses leave in acceptance order on valid/ready.
//
// Ports:
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_op/req_a/req_b       operation and operands
//   req_tag                  opaque tag carried to the response
//   resp_valid/resp_ready    response handshake (FIFO head)
//   resp_result              ALU result
//   resp_neg/zero/ovf        ALU flags
//   resp_tag                 tag of the originating request
//   aluif                    alu_if.tb connection to the ALU
//   stat_issued, stat_ovf    saturating counters (only with ALU_ISSUE_STATS_EN)
//
// Build option: define ALU_ISSUE_STATS_EN to add the statistics counters.
module alu_issue_unit #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_result,
  output logic             resp_neg,
  output logic             resp_zero,
  output logic             resp_ovf,
  output logic [TAG_W-1:0] resp_tag,
`ifdef ALU_ISSUE_STATS_EN
  output logic [31:0]      stat_issued,
  output logic [31:0]      stat_ovf,
`endif
  alu_if.tb                aluif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 32 + 3 + TAG_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Issue register
  logic             issue_vld_q, issue_vld_d;
  logic [3:0]       issue_op_q, issue_op_d;
  logic [31:0]      issue_a_q, issue_a_d;
  logic [31:0]      issue_b_q, issue_b_d;
  logic [TAG_W-1:0] issue_tag_q, issue_tag_d;

  // Response FIFO
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic [ENT_W-1:0] push_entry_s;
  logic [ENT_W-1:0] head_s;

  // Flow control: counting the in-flight issue slot guarantees a FIFO slot
  // for every accepted request, so ready never depends on resp_ready.
  always_comb begin
    req_ready = !RST && ((count_q + CNT_W'(issue_vld_q)) < DEPTH_C);
    accept_s  = req_valid && req_ready;
  end

  // Issue register next state; operands hold while idle so the ALU inputs do not toggle.
  always_comb begin
    issue_vld_d = accept_s;
    if (accept_s) begin
      issue_op_d  = req_op;
      issue_a_d   = req_a;
      issue_b_d   = req_b;
      issue_tag_d = req_tag;
    end else begin
      issue_op_d  = issue_op_q;
      issue_a_d   = issue_a_q;
      issue_b_d   = issue_b_q;
      issue_tag_d = issue_tag_q;
    end
  end

  // FIFO control: push whatever the ALU returned for last cycle's issue.
  always_comb begin
    push_s       = issue_vld_q;
    pop_s        = resp_valid && resp_ready;
    push_entry_s = {aluif.result, aluif.negative, aluif.zero, aluif.overflow, issue_tag_q};
    wptr_d       = push_s ? (wptr_q + PTR_W'(1)) : wptr_q;
    rptr_d       = pop_s  ? (rptr_q + PTR_W'(1)) : rptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Issue and FIFO control registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      issue_vld_q <= 1'b0;
      issue_op_q  <= 4'd0;
      issue_a_q   <= 32'd0;
      issue_b_q   <= 32'd0;
      issue_tag_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      issue_vld_q <= issue_vld_d;
      issue_op_q  <= issue_op_d;
      issue_a_q   <= issue_a_d;
      issue_b_q   <= issue_b_d;
      issue_tag_q <= issue_tag_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push_s && !RST) begin
      mem_q[wptr_q] <= push_entry_s;
    end
  end

  // Drive ALU and response outputs straight from registered state.
  always_comb begin
    aluif.op       = issue_op_q;
    aluif.operand1 = issue_a_q;
    aluif.operand2 = issue_b_q;
    head_s         = mem_q[rptr_q];
    resp_valid     = (count_q != '0);
    resp_result    = head_s[ENT_W-1 -: 32];
    resp_neg       = head_s[TAG_W+2];
    resp_zero      = head_s[TAG_W+1];
    resp_ovf       = head_s[TAG_W];
    resp_tag       = head_s[TAG_W-1:0];
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_ovf_q, stat_ovf_d;

  // Saturating statistics counters.
  always_comb begin
    if (accept_s && (stat_issued_q != 32'hFFFF_FFFF)) begin
      stat_issued_d = stat_issued_q + 32'd1;
    end else begin
      stat_issued_d = stat_issued_q;
    end
    if (push_s && aluif.overflow && (stat_ovf_q != 32'hFFFF_FFFF)) begin
      stat_ovf_d = stat_ovf_q + 32'd1;
    end else begin
      stat_ovf_d = stat_ovf_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_issued_q <= 32'd0;
      stat_ovf_q    <= 32'd0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_ovf_q    <= stat_ovf_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_ovf    = stat_ovf_q;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;
  localparam int TAG_W = 4;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;

  logic             CLK;
  logic             RST;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_result;
  logic             resp_neg;
  logic             resp_zero;
  logic             resp_ovf;
  logic [TAG_W-1:0] resp_tag;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0]      stat_issued;
  logic [31:0]      stat_ovf;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  alu_if aluif();

  // Reference combinational ALU shared through the interface.
  logic [31:0] alu_res;
  logic        alu_ovf;
  always_comb begin
    alu_res = 32'd0;
    alu_ovf = 1'b0;
    case (aluif.op)
      OP_ADD: begin
        alu_res = aluif.operand1 + aluif.operand2;
        alu_ovf = (aluif.operand1[31] == aluif.operand2[31]) && (alu_res[31] != aluif.operand1[31]);
      end
      OP_SUB: begin
        alu_res = aluif.operand1 - aluif.operand2;
        alu_ovf = (aluif.operand1[31] != aluif.operand2[31]) && (alu_res[31] != aluif.operand1[31]);
      end
      OP_AND:  alu_res = aluif.operand1 & aluif.operand2;
      OP_OR:   alu_res = aluif.operand1 | aluif.operand2;
      default: alu_res = 32'd0;
    endcase
  end
  assign aluif.result   = alu_res;
  assign aluif.negative = alu_res[31];
  assign aluif.zero     = (alu_res == 32'd0);
  assign aluif.overflow = alu_ovf;

  alu_issue_unit #(.DEPTH(4), .TAG_W(TAG_W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_tag     (req_tag),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_neg    (resp_neg),
    .resp_zero   (resp_zero),
    .resp_ovf    (resp_ovf),
    .resp_tag    (resp_tag),
`ifdef ALU_ISSUE_STATS_EN
    .stat_issued (stat_issued),
    .stat_ovf    (stat_ovf),
`endif
    .aluif       (aluif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag);
    req_valid = v;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
  endtask

  int t;
  int exp_idx;
  int nresp;
  int first_c;
  int last_c;
  int gaps;
  int stalls;
  int bad;
  int stale;
  logic rdy;
  logic saw_ready;

  initial begin
    RST        = 1'b1;
    resp_ready = 1'b0;
    set_req(1'b0, 4'd0, 32'd0, 32'd0, '0);

    // Reset state
    tick();
    tick();
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_alu_op", aluif.op, 4'd0);
    check("rst_alu_a", aluif.operand1, 32'd0);
    check("rst_alu_b", aluif.operand2, 32'd0);
    RST = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 1'b1);

    // Single ADD 5+7, tag 3: presented after edge k, sampled at k+1, visible after k+2
    resp_ready = 1'b1;
    set_req(1'b1, OP_ADD, 32'd5, 32'd7, 4'd3);
    tick();
    req_valid = 1'b0;
    check("add_not_yet_valid", resp_valid, 1'b0);
    check("add_alu_operand1", aluif.operand1, 32'd5);
    tick();
    check("add_valid", resp_valid, 1'b1);
    check("add_result", resp_result, 32'd12);
    check("add_flags", {resp_neg, resp_zero, resp_ovf}, 3'b000);
    check("add_tag", resp_tag, 4'd3);
    tick();
    check("add_popped", resp_valid, 1'b0);
    check("alu_hold_idle", aluif.operand1, 32'd5);

    // SUB 3-3 then ADD 0x7FFFFFFF+1, held in the FIFO then drained in order
    resp_ready = 1'b0;
    set_req(1'b1, OP_SUB, 32'h0000_0003, 32'h0000_0003, 4'd1);
    tick();
    set_req(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 4'd2);
    tick();
    req_valid = 1'b0;
    tick();
    check("sub_result", resp_result, 32'd0);
    check("sub_flags", {resp_neg, resp_zero, resp_ovf}, 3'b010);
    check("sub_tag", resp_tag, 4'd1);
    resp_ready = 1'b1;
    tick();
    check("ovf_result", resp_result, 32'h8000_0000);
    check("ovf_flags", {resp_neg, resp_zero, resp_ovf}, 3'b101);
    check("ovf_tag", resp_tag, 4'd2);
    tick();
    check("sub_ovf_drained", resp_valid, 1'b0);

    // Backpressure: six requests, tags 0..5, with resp_ready low
    resp_ready = 1'b0;
    t = 0;
    for (int c = 0; c < 8; c++) begin
      if (t < 6) set_req(1'b1, OP_ADD, 32'(t), 32'd100, TAG_W'(t));
      else req_valid = 1'b0;
      rdy = req_ready;
      tick();
      if (rdy && req_valid && t < 6) t++;
    end
    check("fc_accepted", 64'(t), 64'd4);
    check("fc_ready_low", req_ready, 1'b0);
    resp_ready = 1'b1;
    exp_idx    = 0;
    saw_ready  = 1'b0;
    for (int c = 0; c < 30 && exp_idx < 6; c++) begin
      if (resp_valid) begin
        check("fc_tag", resp_tag, TAG_W'(exp_idx));
        check("fc_result", resp_result, 32'(exp_idx + 100));
        exp_idx++;
      end
      if (t < 6) set_req(1'b1, OP_ADD, 32'(t), 32'd100, TAG_W'(t));
      else req_valid = 1'b0;
      rdy = req_ready;
      if (rdy) saw_ready = 1'b1;
      tick();
      if (rdy && req_valid && t < 6) t++;
    end
    req_valid = 1'b0;
    check("fc_all_responses", 64'(exp_idx), 64'd6);
    check("fc_ready_reasserted", saw_ready, 1'b1);
    tick();
    check("fc_drained", resp_valid, 1'b0);

    // Streaming 16 requests with resp_ready high; pointers wrap several times
    resp_ready = 1'b1;
    nresp = 0; first_c = -1; last_c = -1; gaps = 0; stalls = 0; bad = 0;
    for (int c = 0; c < 24; c++) begin
      if (resp_valid) begin
        if (resp_tag !== TAG_W'(nresp) || resp_result !== 32'(4 * nresp)) bad++;
        if (first_c < 0) first_c = c;
        else if (last_c != c - 1) gaps++;
        last_c = c;
        nresp++;
      end
      if (c < 16) begin
        set_req(1'b1, OP_ADD, 32'(3 * c), 32'(c), TAG_W'(c));
        if (!req_ready) stalls++;
      end else begin
        req_valid = 1'b0;
      end
      tick();
    end
    check("stream_count", 64'(nresp), 64'd16);
    check("stream_first_cycle", 64'(first_c), 64'd2);
    check("stream_gaps", 64'(gaps), 64'd0);
    check("stream_stalls", 64'(stalls), 64'd0);
    check("stream_data", 64'(bad), 64'd0);

    // Reset with two entries queued and one in the issue stage
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, OP_SUB, 32'hDEAD_0000 + 32'(i), 32'h0000_0001, TAG_W'(7 + i));
      tick();
    end
    check("prerst_valid", resp_valid, 1'b1);
    check("prerst_alu_op", aluif.op, OP_SUB);
    RST = 1'b1;
    set_req(1'b1, OP_OR, 32'h0000_FFFF, 32'h0000_0001, 4'd10);
    #1;
    check("rst_hi_ready", req_ready, 1'b0);
    tick();
    check("rst_pulse_valid", resp_valid, 1'b0);
    check("rst_pulse_op", aluif.op, 4'd0);
    check("rst_pulse_a", aluif.operand1, 32'd0);
    check("rst_pulse_b", aluif.operand2, 32'd0);
    RST = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rst_pulse_ready", req_ready, 1'b1);
    resp_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (resp_valid) stale++;
    end
    check("rst_no_stale", 64'(stale), 64'd0);

`ifdef ALU_ISSUE_STATS_EN
    // Ten requests, three of them overflowing
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 5 || i == 8) set_req(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, TAG_W'(i));
      else set_req(1'b1, OP_ADD, 32'(i), 32'(i), TAG_W'(i));
      tick();
    end
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    check("stat_issued", stat_issued, 32'd10);
    check("stat_ovf", stat_ovf, 32'd3);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("stat_issued_rst", stat_issued, 32'd0);
    check("stat_ovf_rst", stat_ovf, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
